dec_stage: RTL and testbench

- RV32I decode stage directly downstream of the fetch unit; consumes fetched PC/instruction each cycle.
- Produces a registered decoded bundle for execute.
- Resolves JAL early: redirects fetch via flush_from_dec/flush_addr_dec and squashes the wrong-path instruction(s) already in flight.
- Honours execute stall and execute flush.

---
 rtl/dec_pkg.sv | 61 ++++++
 rtl/dec_decoder.sv | 144 ++++++++++++++
 rtl/dec_stage.sv | 126 ++++++++++++
 tb/tb_dec_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared decode definitions: opcodes, operation classes, ALU ops, immediate formats
// and the registered bundle handed to execute.
package dec_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL,
        CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_SYSTEM, CLS_FENCE
    } op_class_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_e;

    typedef enum logic {
        ST_RUN, ST_KILL
    } dec_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        op_class_e   cls;
        alu_op_e     aluOp;
        logic        rdWe;
        logic        illegal;
    } dec_bundle_t;

    function automatic logic [31:0] genImm(input imm_type_e immType, input logic [31:0] instr);
        logic [31:0] imm;
        case (immType)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'h000};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/dec_decoder.sv
// Purely combinational RV32I instruction decoder: fields, immediate, class, ALU op
// and legality of a single 32-bit instruction word.
module dec_decoder
    import dec_pkg::*;
(
    input  logic [31:0] instr_i,
    output op_class_e   cls_o,
    output alu_op_e     alu_op_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic [31:0] imm_o,
    output logic        rd_we_o,
    output logic        illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       useRs1;
    logic       useRs2;
    logic       useRd;
    logic       altOk;
    imm_type_e  immType;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // funct7=0100000 is only meaningful for SUB and SRA/SRAI
    assign altOk = (funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101));

    always_comb begin
        cls_o     = CLS_ALU_R;
        alu_op_o  = ALU_ADD;
        immType   = IMM_NONE;
        useRs1    = 1'b0;
        useRs2    = 1'b0;
        useRd     = 1'b0;
        illegal_o = 1'b0;

        case (opcode)
            OPC_OP: begin
                cls_o  = CLS_ALU_R;
                useRs1 = 1'b1;
                useRs2 = 1'b1;
                useRd  = 1'b1;
                case (funct3)
                    3'b000:  alu_op_o = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op_o = ALU_SLL;
                    3'b010:  alu_op_o = ALU_SLT;
                    3'b011:  alu_op_o = ALU_SLTU;
                    3'b100:  alu_op_o = ALU_XOR;
                    3'b101:  alu_op_o = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op_o = ALU_OR;
                    default: alu_op_o = ALU_AND;
                endcase
                illegal_o = !((funct7 == 7'b0) || altOk);
            end
            OPC_OP_IMM: begin
                cls_o   = CLS_ALU_I;
                immType = IMM_I;
                useRs1  = 1'b1;
                useRd   = 1'b1;
                case (funct3)
                    3'b000:  alu_op_o = ALU_ADD;
                    3'b001:  alu_op_o = ALU_SLL;
                    3'b010:  alu_op_o = ALU_SLT;
                    3'b011:  alu_op_o = ALU_SLTU;
                    3'b100:  alu_op_o = ALU_XOR;
                    3'b101:  alu_op_o = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op_o = ALU_OR;
                    default: alu_op_o = ALU_AND;
                endcase
                if (funct3 == 3'b001)
                    illegal_o = (funct7 != 7'b0);
                else if (funct3 == 3'b101)
                    illegal_o = !((funct7 == 7'b0) || altOk);
            end
            OPC_LOAD: begin
                cls_o     = CLS_LOAD;
                immType   = IMM_I;
                useRs1    = 1'b1;
                useRd     = 1'b1;
                illegal_o = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                cls_o     = CLS_STORE;
                immType   = IMM_S;
                useRs1    = 1'b1;
                useRs2    = 1'b1;
                illegal_o = (funct3[2] || (funct3[1:0] == 2'b11));
            end
            OPC_BRANCH: begin
                cls_o     = CLS_BRANCH;
                immType   = IMM_B;
                useRs1    = 1'b1;
                useRs2    = 1'b1;
                alu_op_o  = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                illegal_o = (funct3[2:1] == 2'b01);
            end
            OPC_JAL: begin
                cls_o   = CLS_JAL;
                immType = IMM_J;
                useRd   = 1'b1;
            end
            OPC_JALR: begin
                cls_o     = CLS_JALR;
                immType   = IMM_I;
                useRs1    = 1'b1;
                useRd     = 1'b1;
                illegal_o = (funct3 != 3'b000);
            end
            OPC_LUI: begin
                cls_o   = CLS_LUI;
                immType = IMM_U;
                useRd   = 1'b1;
            end
            OPC_AUIPC: begin
                cls_o   = CLS_AUIPC;
                immType = IMM_U;
                useRd   = 1'b1;
            end
            OPC_FENCE: begin
                cls_o     = CLS_FENCE;
                illegal_o = (funct3 != 3'b000);
            end
            OPC_SYSTEM: begin
                // Only ECALL/EBREAK; CSR access belongs to an extension not supported here
                cls_o     = CLS_SYSTEM;
                immType   = IMM_I;
                illegal_o = (funct3 != 3'b000);
            end
            default: illegal_o = 1'b1;
        endcase
    end

    assign rs1_o   = useRs1 ? instr_i[19:15] : 5'd0;
    assign rs2_o   = useRs2 ? instr_i[24:20] : 5'd0;
    assign rd_o    = useRd  ? instr_i[11:7]  : 5'd0;
    assign imm_o   = genImm(immType, instr_i);
    assign rd_we_o = useRd && (instr_i[11:7] != 5'd0) && !illegal_o;

endmodule

// File: rtl/dec_stage.sv
// RV32I decode stage: registers the decoded bundle for execute, resolves JAL early
// and squashes the fetch shadow behind a decode redirect.
module dec_stage
    import dec_pkg::*;
#(
    parameter int unsigned KILL_CYCLES = 1,
    parameter int unsigned XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr_location_i,
    input  logic [31:0]     instr_i,
    input  logic            exe_stall_i,
    input  logic            flush_from_exe,
    output logic            ifu_stall_o,
    output logic            flush_from_dec,
    output logic [XLEN-1:0] flush_addr_dec,
    output logic            dec_valid_o,
    output logic [XLEN-1:0] dec_pc_o,
    output logic [4:0]      dec_rs1_o,
    output logic [4:0]      dec_rs2_o,
    output logic [4:0]      dec_rd_o,
    output logic [31:0]     dec_imm_o,
    output logic [3:0]      dec_class_o,
    output logic [3:0]      dec_alu_op_o,
    output logic            dec_rd_we_o,
    output logic            dec_illegal_o
);

    localparam logic [1:0] KILL_INIT = 2'(KILL_CYCLES);

    op_class_e   decCls;
    alu_op_e     decAlu;
    logic [4:0]  decRs1;
    logic [4:0]  decRs2;
    logic [4:0]  decRd;
    logic [31:0] decImm;
    logic        decRdWe;
    logic        decIll;
    logic        isBubble;
    logic        jalHit;

    dec_state_e  state_q, state_d;
    logic [1:0]  killCnt_q, killCnt_d;
    dec_bundle_t out_q, out_d;

    dec_decoder u_decoder (
        .instr_i   (instr_i),
        .cls_o     (decCls),
        .alu_op_o  (decAlu),
        .rs1_o     (decRs1),
        .rs2_o     (decRs2),
        .rd_o      (decRd),
        .imm_o     (decImm),
        .rd_we_o   (decRdWe),
        .illegal_o (decIll)
    );

    assign isBubble = (instr_i == 32'h0);
    assign jalHit   = (state_q == ST_RUN) && !isBubble && (decCls == CLS_JAL) && !decIll
                      && !flush_from_exe && !exe_stall_i;

    assign ifu_stall_o    = exe_stall_i;
    assign flush_from_dec = jalHit;
    assign flush_addr_dec = instr_location_i + decImm;

    // Execute flush beats stall; in KILL every accepted slot is dropped
    always_comb begin
        state_d   = state_q;
        killCnt_d = killCnt_q;
        out_d     = out_q;
        if (flush_from_exe) begin
            out_d     = '0;
            state_d   = ST_RUN;
            killCnt_d = 2'd0;
        end else if (!exe_stall_i) begin
            out_d = '0;
            if (state_q == ST_RUN) begin
                if (!isBubble) begin
                    out_d.valid   = 1'b1;
                    out_d.pc      = instr_location_i;
                    out_d.rs1     = decRs1;
                    out_d.rs2     = decRs2;
                    out_d.rd      = decRd;
                    out_d.imm     = decImm;
                    out_d.cls     = decCls;
                    out_d.aluOp   = decAlu;
                    out_d.rdWe    = decRdWe;
                    out_d.illegal = decIll;
                end
                if (jalHit) begin
                    state_d   = ST_KILL;
                    killCnt_d = KILL_INIT;
                end
            end else begin
                killCnt_d = killCnt_q - 2'd1;
                if (killCnt_q == 2'd1)
                    state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            killCnt_q <= 2'd0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            killCnt_q <= killCnt_d;
            out_q     <= out_d;
        end
    end

    assign dec_valid_o   = out_q.valid;
    assign dec_pc_o      = out_q.pc;
    assign dec_rs1_o     = out_q.rs1;
    assign dec_rs2_o     = out_q.rs2;
    assign dec_rd_o      = out_q.rd;
    assign dec_imm_o     = out_q.imm;
    assign dec_class_o   = out_q.cls;
    assign dec_alu_op_o  = out_q.aluOp;
    assign dec_rd_we_o   = out_q.rdWe;
    assign dec_illegal_o = out_q.illegal;

endmodule

// File: tb/tb_dec_stage.sv
// Directed scoreboard bench for dec_stage: reset, JAL redirect and shadow kill,
// stall/flush priority, immediates, illegal and bubble handling.
module tb_dec_stage;
    import dec_pkg::*;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  cls;
        logic [3:0]  alu;
        logic        rdwe;
        logic        ill;
        logic        full;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_location_i;
    logic [31:0] instr_i;
    logic        exe_stall_i;
    logic        flush_from_exe;
    logic        ifu_stall_o;
    logic        flush_from_dec;
    logic [31:0] flush_addr_dec;
    logic        dec_valid_o;
    logic [31:0] dec_pc_o;
    logic [4:0]  dec_rs1_o;
    logic [4:0]  dec_rs2_o;
    logic [4:0]  dec_rd_o;
    logic [31:0] dec_imm_o;
    logic [3:0]  dec_class_o;
    logic [3:0]  dec_alu_op_o;
    logic        dec_rd_we_o;
    logic        dec_illegal_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sbQ[$];
    exp_t lastExp;

    dec_stage #(.KILL_CYCLES(1), .XLEN(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .instr_location_i (instr_location_i),
        .instr_i          (instr_i),
        .exe_stall_i      (exe_stall_i),
        .flush_from_exe   (flush_from_exe),
        .ifu_stall_o      (ifu_stall_o),
        .flush_from_dec   (flush_from_dec),
        .flush_addr_dec   (flush_addr_dec),
        .dec_valid_o      (dec_valid_o),
        .dec_pc_o         (dec_pc_o),
        .dec_rs1_o        (dec_rs1_o),
        .dec_rs2_o        (dec_rs2_o),
        .dec_rd_o         (dec_rd_o),
        .dec_imm_o        (dec_imm_o),
        .dec_class_o      (dec_class_o),
        .dec_alu_op_o     (dec_alu_op_o),
        .dec_rd_we_o      (dec_rd_we_o),
        .dec_illegal_o    (dec_illegal_o)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                                input logic [3:0] cls, input logic [3:0] alu, input logic rdwe,
                                input logic ill, input logic full);
        exp_t e;
        e.valid = v;   e.pc  = pc;  e.rs1  = rs1;  e.rs2 = rs2; e.rd = rd;
        e.imm   = imm; e.cls = cls; e.alu  = alu;  e.rdwe = rdwe;
        e.ill   = ill; e.full = full;
        return e;
    endfunction

    function automatic exp_t dropped();
        return mk(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("dec_valid_o", 32'(dec_valid_o), 32'(e.valid));
        checkField("dec_illegal_o", 32'(dec_illegal_o), 32'(e.ill));
        if (e.full) begin
            checkField("dec_pc_o", dec_pc_o, e.pc);
            checkField("dec_rs1_o", 32'(dec_rs1_o), 32'(e.rs1));
            checkField("dec_rs2_o", 32'(dec_rs2_o), 32'(e.rs2));
            checkField("dec_rd_o", 32'(dec_rd_o), 32'(e.rd));
            checkField("dec_imm_o", dec_imm_o, e.imm);
            checkField("dec_class_o", 32'(dec_class_o), 32'(e.cls));
            checkField("dec_alu_op_o", 32'(dec_alu_op_o), 32'(e.alu));
            checkField("dec_rd_we_o", 32'(dec_rd_we_o), 32'(e.rdwe));
        end else begin
            checkField("dec_rd_we_o", 32'(dec_rd_we_o), 32'(e.rdwe));
        end
    endtask

    // Drive one cycle at the negedge, check combinational outputs, then the registered bundle
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr, input logic stall,
                                 input logic exFlush, input exp_t e, input logic expFlush,
                                 input logic [31:0] expAddr);
        exp_t got;
        instr_location_i = pc;
        instr_i          = instr;
        exe_stall_i      = stall;
        flush_from_exe   = exFlush;
        #1;
        checkField("flush_from_dec", 32'(flush_from_dec), 32'(expFlush));
        if (expFlush)
            checkField("flush_addr_dec", flush_addr_dec, expAddr);
        checkField("ifu_stall_o", 32'(ifu_stall_o), 32'(stall));
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        got = sbQ.pop_front();
        checkOutput(got);
        lastExp = got;
        @(negedge clk);
    endtask

    initial begin
        exp_t zeroFull;
        zeroFull = mk(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);

        rst = 1'b1; instr_location_i = 32'h0; instr_i = 32'h0;
        exe_stall_i = 1'b0; flush_from_exe = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput(zeroFull);
        rst = 1'b0;

        // Basic ALU-immediate decode, including negative immediate
        applyStimulus(32'h4, 32'h00500293, 0, 0,
            mk(1, 32'h4, 0, 0, 5, 32'h5, CLS_ALU_I, ALU_ADD, 1, 0, 1), 0, 0);
        applyStimulus(32'h8, 32'hFFF00093, 0, 0,
            mk(1, 32'h8, 0, 0, 1, 32'hFFFFFFFF, CLS_ALU_I, ALU_ADD, 1, 0, 1), 0, 0);

        // JAL redirect, shadow instruction dropped, target accepted
        applyStimulus(32'h10, 32'h008000EF, 0, 0,
            mk(1, 32'h10, 0, 0, 1, 32'h8, CLS_JAL, ALU_ADD, 1, 0, 1), 1, 32'h18);
        applyStimulus(32'h14, 32'h00100013, 0, 0, dropped(), 0, 0);
        applyStimulus(32'h18, 32'h00500293, 0, 0,
            mk(1, 32'h18, 0, 0, 5, 32'h5, CLS_ALU_I, ALU_ADD, 1, 0, 1), 0, 0);

        // Stall with JAL waiting: outputs held, no redirect until release
        for (int i = 0; i < 3; i++)
            applyStimulus(32'h1C, 32'h008000EF, 1, 0, lastExp, 0, 0);
        applyStimulus(32'h1C, 32'h008000EF, 0, 0,
            mk(1, 32'h1C, 0, 0, 1, 32'h8, CLS_JAL, ALU_ADD, 1, 0, 1), 1, 32'h24);
        applyStimulus(32'h20, 32'h008000EF, 0, 0, dropped(), 0, 0);

        // Execute flush while in KILL, with stall also high
        applyStimulus(32'h24, 32'h008000EF, 0, 0,
            mk(1, 32'h24, 0, 0, 1, 32'h8, CLS_JAL, ALU_ADD, 1, 0, 1), 1, 32'h2C);
        applyStimulus(32'h28, 32'h008000EF, 1, 1, dropped(), 0, 0);
        applyStimulus(32'h40, 32'h00100013, 0, 0,
            mk(1, 32'h40, 0, 0, 0, 32'h1, CLS_ALU_I, ALU_ADD, 0, 0, 1), 0, 0);

        // JAL coinciding with execute flush: dropped, no redirect, no kill
        applyStimulus(32'h44, 32'h008000EF, 0, 1, dropped(), 0, 0);
        applyStimulus(32'h48, 32'h00500293, 0, 0,
            mk(1, 32'h48, 0, 0, 5, 32'h5, CLS_ALU_I, ALU_ADD, 1, 0, 1), 0, 0);

        // Illegal opcode and bubble
        applyStimulus(32'h4C, 32'h0000007F, 0, 0,
            mk(1, 32'h0, 0, 0, 0, 32'h0, 4'd0, 4'd0, 0, 1, 0), 0, 0);
        applyStimulus(32'h50, 32'h00000000, 0, 0, dropped(), 0, 0);

        // Store, branch, LUI, R-type SUB, load with negative offset
        applyStimulus(32'h54, 32'h00512223, 0, 0,
            mk(1, 32'h54, 2, 5, 0, 32'h4, CLS_STORE, ALU_ADD, 0, 0, 1), 0, 0);
        applyStimulus(32'h58, 32'hFE208EE3, 0, 0,
            mk(1, 32'h58, 1, 2, 0, 32'hFFFFFFFC, CLS_BRANCH, ALU_SUB, 0, 0, 1), 0, 0);
        applyStimulus(32'h5C, 32'h123451B7, 0, 0,
            mk(1, 32'h5C, 0, 0, 3, 32'h12345000, CLS_LUI, ALU_ADD, 1, 0, 1), 0, 0);
        applyStimulus(32'h60, 32'h402081B3, 0, 0,
            mk(1, 32'h60, 1, 2, 3, 32'h0, CLS_ALU_R, ALU_SUB, 1, 0, 1), 0, 0);
        applyStimulus(32'h64, 32'hFF812303, 0, 0,
            mk(1, 32'h64, 2, 0, 6, 32'hFFFFFFF8, CLS_LOAD, ALU_ADD, 1, 0, 1), 0, 0);

        // Backward JAL to x0, then asynchronous reset while in KILL
        applyStimulus(32'h100, 32'hFF1FF06F, 0, 0,
            mk(1, 32'h100, 0, 0, 0, 32'hFFFFFFF0, CLS_JAL, ALU_ADD, 0, 0, 1), 1, 32'hF0);
        instr_i = 32'h0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput(zeroFull);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'h4, 32'h00500293, 0, 0,
            mk(1, 32'h4, 0, 0, 5, 32'h5, CLS_ALU_I, ALU_ADD, 1, 0, 1), 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
